keypad_scanner: RTL and testbench

Input-side counterpart to the multiplexed seven-segment display driver. It scans a 4x4 active-low matrix keypad one column at a time, synchronizes and debounces the row returns, and reports each accepted key press once as a 4-bit code. Its outputs feed the board-level digit/counter logic, so user entry shares the same 100 MHz clock and button-reset scheme as the display path.

---
 rtl/keypad_scanner.sv | 143 ++++++++++++++
 tb/tb_keypad_scanner.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: column drive, row synchroniser,
// per-scan single/multi/none classification, scan-level debounce and press FSM.
module keypad_scanner #(
  parameter int unsigned SCAN_TOP       = 100000 - 1,
  parameter int unsigned DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_btn,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned DIV_W = (SCAN_TOP < 1) ? 1 : $clog2(SCAN_TOP + 1);
  localparam logic [DIV_W-1:0] DIV_TOP = DIV_W'(SCAN_TOP);
  localparam logic [3:0]       DEB_TOP = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_kind_t;
  typedef enum logic {IDLE, PRESSED} state_t;

  logic [DIV_W-1:0] div;
  logic [1:0]       col;
  logic [3:0]       rows_meta, rows_sync;
  res_kind_t        acc_kind, nxt_kind, prev_kind;
  logic [3:0]       acc_code, nxt_code, res_code, prev_code;
  logic [3:0]       stable_cnt;
  logic             scan_done;
  state_t           state;

  logic [3:0] low;
  logic [2:0] n_low;
  logic [1:0] row_idx;
  logic       tick, stable;

  assign tick   = (div == DIV_TOP);
  assign cols   = ~(4'b0001 << col);
  assign stable = (stable_cnt == DEB_TOP);

  // Merge the current column's sample into the running scan result.
  always_comb begin
    low     = ~rows_sync;
    n_low   = '0;
    row_idx = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      if (low[r]) begin
        n_low   = n_low + 3'd1;
        row_idx = 2'(r);
      end
    end
    nxt_kind = acc_kind;
    nxt_code = acc_code;
    if (n_low > 3'd1) begin
      nxt_kind = RES_MULTI;
    end else if (n_low == 3'd1) begin
      if (acc_kind == RES_NONE) begin
        nxt_kind = RES_SINGLE;
        nxt_code = {row_idx, col};
      end else begin
        nxt_kind = RES_MULTI;
      end
    end
    // Code is only meaningful for SINGLE; zero it so NONE/MULTI compare equal scan to scan.
    res_code = (nxt_kind == RES_SINGLE) ? nxt_code : '0;
  end

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      rows_meta <= '1;
      rows_sync <= '1;
    end else begin
      rows_meta <= rows;
      rows_sync <= rows_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      div        <= '0;
      col        <= '0;
      acc_kind   <= RES_NONE;
      acc_code   <= '0;
      prev_kind  <= RES_NONE;
      prev_code  <= '0;
      stable_cnt <= '0;
      scan_done  <= 1'b0;
    end else begin
      scan_done <= tick && (col == 2'd3);
      if (tick) begin
        div <= '0;
        col <= col + 2'd1;
        if (col == 2'd3) begin
          acc_kind <= RES_NONE;
          acc_code <= '0;
          if (nxt_kind == prev_kind && res_code == prev_code) begin
            if (stable_cnt != DEB_TOP) stable_cnt <= stable_cnt + 4'd1;
          end else begin
            stable_cnt <= 4'd1;
            prev_kind  <= nxt_kind;
            prev_code  <= res_code;
          end
        end else begin
          acc_kind <= nxt_kind;
          acc_code <= nxt_code;
        end
      end else begin
        div <= div + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_btn) begin
    if (!rst_btn) begin
      state     <= IDLE;
      key       <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (scan_done) begin
        case (state)
          IDLE: begin
            if (stable && prev_kind == RES_SINGLE) begin
              state     <= PRESSED;
              key       <= prev_code;
              key_valid <= 1'b1;
              key_held  <= 1'b1;
            end
          end
          PRESSED: begin
            if (stable && prev_kind == RES_NONE) begin
              state    <= IDLE;
              key_held <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: directed key patterns on a modelled
// matrix; expected pulses are queued by the stimulus and matched by a monitor.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_btn = 1'b0;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed = '0;
  int edge_n = 0;
  int checks = 0;
  int failures = 0;
  logic prev_kv = 1'b0;

  typedef struct {
    logic [3:0] key;
    int         at;
  } exp_t;
  exp_t exp_q[$];

  keypad_scanner #(.SCAN_TOP(3), .DEBOUNCE_SCANS(3)) dut (
    .clk      (clk),
    .rst_btn  (rst_btn),
    .rows     (rows),
    .cols     (cols),
    .key      (key),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_btn) edge_n <= 0;
    else          edge_n <= edge_n + 1;
  end

  always_comb begin
    rows = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  // Monitor: every key_valid pulse must match the head of the queue.
  always @(negedge clk) begin
    if (rst_btn && key_valid) begin
      exp_t e;
      checks++;
      if (prev_kv) begin
        failures++;
        $display("FAIL pulse_width: key_valid high two cycles at edge %0d, required one", edge_n);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: key=%0d at edge %0d, required no pulse", key, edge_n);
      end else begin
        e = exp_q.pop_front();
        if (e.key !== key || e.at != edge_n) begin
          failures++;
          $display("FAIL pulse_match: key=%0d edge=%0d, required key=%0d edge=%0d",
                   key, edge_n, e.key, e.at);
        end
      end
    end
    prev_kv = key_valid;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (edge %0d)", name, act, req, edge_n);
    end
  endtask

  task automatic goto(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  task automatic boundary(output int b);
    b = ((edge_n / 16) + 1) * 16;
    goto(b);
  endtask

  task automatic expect_pulse(input logic [3:0] k, input int at);
    exp_t e;
    e.key = k;
    e.at  = at;
    exp_q.push_back(e);
  endtask

  task automatic check_queue_drained(input string name);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    // Reset state, with key 9 (row 2, col 1) already held.
    rst_btn = 1'b0;
    pressed = '0;
    pressed[9] = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cols", cols, 4'b1110);
    chk("rst_key", key, 0);
    chk("rst_valid", key_valid, 0);
    chk("rst_held", key_held, 0);
    expect_pulse(4'd9, 49);
    rst_btn = 1'b1;
    goto(3);  chk("cols_e3", cols, 4'b1110);
    goto(4);  chk("cols_e4", cols, 4'b1101);
    goto(8);  chk("cols_e8", cols, 4'b1011);
    goto(12); chk("cols_e12", cols, 4'b0111);
    goto(16); chk("cols_e16", cols, 4'b1110);
    goto(48); chk("pre_pulse_held", key_held, 0);
    goto(49); chk("accept_held", key_held, 1);
    goto(50); chk("pulse_low_e50", key_valid, 0);
    chk("accept_key", key, 9);
    goto(49 + 320);
    chk("hold_20_scans", key_held, 1);
    check_queue_drained("queue_after_first");

    // Release after accept, then re-press key 0.
    boundary(b);
    pressed = '0;
    goto(b + 48); chk("release_held_still", key_held, 1);
    pressed[0] = 1'b1;
    expect_pulse(4'd0, b + 97);
    goto(b + 49); chk("release_held_fall", key_held, 0);
    chk("release_key_kept", key, 9);
    goto(b + 98);
    chk("repress_key", key, 0);
    chk("repress_held", key_held, 1);

    // Release key 0, then bounce key 9 on alternating scans.
    boundary(b);
    pressed = '0;
    goto(b + 49); chk("release0_held", key_held, 0);
    boundary(b);
    for (int i = 0; i < 10; i++) begin
      pressed = '0;
      pressed[9] = (i % 2 == 0);
      goto(b + 16 * (i + 1));
    end
    pressed = '0;
    goto(b + 16 * 14);
    chk("bounce_held", key_held, 0);

    // Two keys from IDLE: never accepted.
    boundary(b);
    pressed[9] = 1'b1;
    pressed[0] = 1'b1;
    goto(b + 16 * 5 + 2); chk("multi_idle_held", key_held, 0);
    boundary(b);
    pressed = '0;
    goto(b + 16 * 4);

    // Key 9, add key 6, drop key 9: one pulse only, held until full release.
    boundary(b);
    pressed[9] = 1'b1;
    expect_pulse(4'd9, b + 49);
    goto(b + 50); chk("rollover_accept_held", key_held, 1);
    boundary(b);
    pressed[6] = 1'b1;
    goto(b + 16 * 5 + 2);
    chk("multi_pressed_held", key_held, 1);
    chk("multi_pressed_key", key, 9);
    boundary(b);
    pressed[9] = 1'b0;
    goto(b + 16 * 5 + 2);
    chk("other_single_held", key_held, 1);
    chk("other_single_key", key, 9);
    boundary(b);
    pressed = '0;
    goto(b + 48); chk("full_release_held_still", key_held, 1);
    goto(b + 49); chk("full_release_held_fall", key_held, 0);

    // Reset mid-press with key 5 (row 1, col 1).
    boundary(b);
    pressed[5] = 1'b1;
    expect_pulse(4'd5, b + 49);
    goto(b + 55);
    chk("key5_held", key_held, 1);
    chk("key5_key", key, 5);
    #2 rst_btn = 1'b0;
    #1;
    chk("midrst_key", key, 0);
    chk("midrst_held", key_held, 0);
    chk("midrst_valid", key_valid, 0);
    chk("midrst_cols", cols, 4'b1110);
    @(negedge clk);
    @(negedge clk);
    expect_pulse(4'd5, 49);
    rst_btn = 1'b1;
    goto(48); chk("redetect_pre_held", key_held, 0);
    goto(60);
    chk("redetect_held", key_held, 1);
    chk("redetect_key", key, 5);
    check_queue_drained("queue_final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
